// File: rtl/sync_param_update_pkg.sv
// ----------------------------------------------------------------------------
// sync_param_pkg
// Shared types and helpers for the synchronized-parameter update path.
//   sp_state_t : commit FSM states (IDLE / SETTLE / PENDING)
//   cnt_width  : bits needed to hold a count from 0 up to and including n
// ----------------------------------------------------------------------------
package sync_param_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } sp_state_t;

    // A saturating counter that must reach n needs room for the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_param_update_if.sv
// ----------------------------------------------------------------------------
// sync_param_update_if
// Bundles the parameter word, frame marker and commit outputs of
// sync_param_update.
//   din_sync    : synchronized parameter word (master -> slave)
//   frame_start : one-cycle frame-boundary pulse (master -> slave)
//   force_load  : immediate commit request, only with SYNC_PARAM_FORCE_EN
//   param_out   : committed parameter (slave -> master)
//   param_upd   : one-cycle pulse when param_out changed (slave -> master)
//   pending     : qualified value awaiting a frame boundary (slave -> master)
// Optional feature macro: SYNC_PARAM_FORCE_EN
// ----------------------------------------------------------------------------
interface sync_param_update_if #(
    parameter int C_DATA_WIDTH = 8
);
    logic [C_DATA_WIDTH-1:0] din_sync;
    logic                    frame_start;
    logic [C_DATA_WIDTH-1:0] param_out;
    logic                    param_upd;
    logic                    pending;
`ifdef SYNC_PARAM_FORCE_EN
    logic                    force_load;

    modport master (
        output din_sync, frame_start, force_load,
        input  param_out, param_upd, pending
    );

    modport slave (
        input  din_sync, frame_start, force_load,
        output param_out, param_upd, pending
    );
`else
    modport master (
        output din_sync, frame_start,
        input  param_out, param_upd, pending
    );

    modport slave (
        input  din_sync, frame_start,
        output param_out, param_upd, pending
    );
`endif
endinterface

// File: rtl/sync_param_update_stable_filter.sv
// ----------------------------------------------------------------------------
// sync_stable_filter
// Stability qualifier for a bus coming out of a two-flop synchronizer. A value
// is "qualified" once it has been sampled identically for C_STABLE_CYCLES
// consecutive cycles plus the current one, which rejects skewed transitions
// where the bits of a multi-bit word arrive on different cycles.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   din        : synchronized input word
//   last_din   : din registered one cycle earlier
//   changed    : din differs from last_din this cycle
//   qualified  : stability count saturated and no change this cycle
// C_STABLE_CYCLES is expected to be at least 2.
// ----------------------------------------------------------------------------
module sync_stable_filter
    import sync_param_pkg::*;
#(
    parameter int                    C_DATA_WIDTH    = 8,
    parameter int                    C_STABLE_CYCLES = 4,
    parameter logic [C_DATA_WIDTH-1:0] C_INIT_VALUE  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_DATA_WIDTH-1:0] din,
    output logic [C_DATA_WIDTH-1:0] last_din,
    output logic                    changed,
    output logic                    qualified
);

    localparam int                 C_CNT_W   = cnt_width(C_STABLE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(C_STABLE_CYCLES);

    logic [C_DATA_WIDTH-1:0] last_din_q, last_din_d;
    logic [C_CNT_W-1:0]      stab_cnt_q, stab_cnt_d;

    // Change detection and the run-length counter. A change restarts the run
    // at 1 because the new value has already been seen once (this cycle).
    always_comb begin
        last_din_d = din;
        changed    = (din != last_din_q);
        stab_cnt_d = stab_cnt_q;
        if (changed) begin
            stab_cnt_d = C_CNT_W'(1);
        end else if (stab_cnt_q != C_CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + C_CNT_W'(1);
        end
    end

    // Sample history and run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_din_q <= C_INIT_VALUE;
            stab_cnt_q <= '0;
        end else begin
            last_din_q <= last_din_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign last_din  = last_din_q;
    assign qualified = (stab_cnt_q == C_CNT_MAX) && !changed;

endmodule

// File: rtl/sync_param_update.sv
// ----------------------------------------------------------------------------
// sync_param_update
// Takes a synchronized multi-bit parameter word, waits until it has been
// stable long enough to trust, and commits it to param_out only at a frame
// boundary so a downstream scaler never sees a mid-frame change.
// Ports:
//   clk  : processing clock (single domain)
//   rst  : synchronous active-high reset
//   bus  : sync_param_update_if.slave carrying din_sync, frame_start,
//          param_out, param_upd, pending (and force_load, see below)
// Optional feature macro: SYNC_PARAM_FORCE_EN
//   When defined, bus.force_load commits immediately: the waiting candidate
//   in PENDING, or the last sampled word (bypassing stability) otherwise.
// ----------------------------------------------------------------------------
module sync_param_update
    import sync_param_pkg::*;
#(
    parameter int                      C_DATA_WIDTH    = 8,
    parameter int                      C_STABLE_CYCLES = 4,
    parameter logic [C_DATA_WIDTH-1:0] C_INIT_VALUE    = '0
) (
    input logic               clk,
    input logic               rst,
    sync_param_update_if.slave bus
);

    sp_state_t               state_q, state_d;
    logic [C_DATA_WIDTH-1:0] candidate_q, candidate_d;
    logic [C_DATA_WIDTH-1:0] param_out_q, param_out_d;
    logic                    param_upd_q, param_upd_d;

    logic [C_DATA_WIDTH-1:0] last_din;
    logic                    changed;
    logic                    qualified;
    logic                    force_req;
    logic                    commit;
    logic [C_DATA_WIDTH-1:0] commit_val;

`ifdef SYNC_PARAM_FORCE_EN
    assign force_req = bus.force_load;
`else
    assign force_req = 1'b0;
`endif

    sync_stable_filter #(
        .C_DATA_WIDTH    (C_DATA_WIDTH),
        .C_STABLE_CYCLES (C_STABLE_CYCLES),
        .C_INIT_VALUE    (C_INIT_VALUE)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .din       (bus.din_sync),
        .last_din  (last_din),
        .changed   (changed),
        .qualified (qualified)
    );

    // Commit decision. In PENDING a frame boundary (or force) loads the
    // candidate. Outside PENDING only force can commit, and it takes the last
    // sampled word directly. Forced commits are held off for one cycle after
    // an update so param_upd can never pulse on back-to-back cycles, and no
    // commit happens if it would not change param_out.
    always_comb begin
        commit     = 1'b0;
        commit_val = candidate_q;
        case (state_q)
            PENDING: begin
                if ((bus.frame_start || force_req) && (candidate_q != param_out_q)) begin
                    commit = 1'b1;
                end
            end
            default: begin
                if (force_req && (last_din != param_out_q) && !param_upd_q) begin
                    commit     = 1'b1;
                    commit_val = last_din;
                end
            end
        endcase
    end

    // State register together with the datapath registers it controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            candidate_q <= C_INIT_VALUE;
            param_out_q <= C_INIT_VALUE;
            param_upd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            candidate_q <= candidate_d;
            param_out_q <= param_out_d;
            param_upd_q <= param_upd_d;
        end
    end

    // Next-state logic. Leaving PENDING on a frame boundary while the input
    // moves at the same time goes straight to SETTLE so the new value starts
    // its stability run from scratch after the commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (changed) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (commit) begin
                    state_d = changed ? SETTLE : IDLE;
                end else if (qualified) begin
                    state_d = (last_din != param_out_q) ? PENDING : IDLE;
                end
            end
            PENDING: begin
                if (bus.frame_start || force_req) begin
                    state_d = changed ? SETTLE : IDLE;
                end else if (changed) begin
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath logic. The candidate is captured on qualification in
    // SETTLE; when PENDING is abandoned on a change it is simply overwritten
    // at the next qualification, so no explicit clear is needed.
    always_comb begin
        candidate_d = candidate_q;
        param_out_d = param_out_q;
        param_upd_d = commit;
        if (commit) begin
            param_out_d = commit_val;
        end
        if ((state_q == SETTLE) && !commit && qualified && (last_din != param_out_q)) begin
            candidate_d = last_din;
        end
    end

    assign bus.param_out = param_out_q;
    assign bus.param_upd = param_upd_q;
    assign bus.pending   = (state_q == PENDING);

endmodule

// File: tb/tb_sync_param_update.sv
// ----------------------------------------------------------------------------
// tb_sync_param_update
// Directed testbench for sync_param_update (width 8, 4 stable cycles,
// init 0). A history-based reference model predicts param_out, param_upd
// and pending every cycle; directed steps add literal expectations.
// Optional feature macro: SYNC_PARAM_FORCE_EN (adds a force_load step).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_param_update;

    localparam int         C_W    = 8;
    localparam int         C_N    = 4;
    localparam logic [7:0] C_INIT = 8'h00;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    sync_param_update_if #(.C_DATA_WIDTH(C_W)) bus ();

    sync_param_update #(
        .C_DATA_WIDTH    (C_W),
        .C_STABLE_CYCLES (C_N),
        .C_INIT_VALUE    (C_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the samples seen since reset. A word is
    // trusted once the last C_N+1 samples are identical; a trusted word that
    // differs from the committed value waits for a frame boundary.
    logic [7:0] hist[$];
    logic [7:0] m_prev    = C_INIT;
    logic [7:0] m_out     = C_INIT;
    logic [7:0] m_cand    = C_INIT;
    logic       m_pending = 1'b0;
    logic       m_upd     = 1'b0;
    logic       m_valid   = 1'b0;

    always @(posedge clk) begin
        logic [7:0] cur;
        logic       is_changed;
        logic       is_qual;
        logic       new_upd;
        logic       frc;
        frc = 1'b0;
`ifdef SYNC_PARAM_FORCE_EN
        frc = bus.force_load;
`endif
        if (rst) begin
            hist.delete();
            m_prev    = C_INIT;
            m_out     = C_INIT;
            m_cand    = C_INIT;
            m_pending = 1'b0;
            m_upd     = 1'b0;
            m_valid   = 1'b1;
        end else begin
            cur        = bus.din_sync;
            is_changed = (cur != m_prev);
            hist.push_back(cur);
            if (hist.size() > C_N + 1) void'(hist.pop_front());
            is_qual = (hist.size() == C_N + 1);
            foreach (hist[k]) if (hist[k] != cur) is_qual = 1'b0;
            new_upd = 1'b0;
            if (m_pending) begin
                if (bus.frame_start || frc) begin
                    if (m_cand != m_out) begin
                        m_out   = m_cand;
                        new_upd = 1'b1;
                    end
                    m_pending = 1'b0;
                end else if (is_changed) begin
                    m_pending = 1'b0;
                end
            end else if (frc && (m_prev != m_out) && !m_upd) begin
                m_out   = m_prev;
                new_upd = 1'b1;
            end else if (is_qual && (cur != m_out)) begin
                m_pending = 1'b1;
                m_cand    = cur;
            end
            m_upd  = new_upd;
            m_prev = cur;
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checks += 3;
            if (bus.param_out !== m_out) begin
                failures++;
                $display("[TB] FAIL model_param_out t=%0t actual=%h expected=%h", $time, bus.param_out, m_out);
            end
            if (bus.param_upd !== m_upd) begin
                failures++;
                $display("[TB] FAIL model_param_upd t=%0t actual=%b expected=%b", $time, bus.param_upd, m_upd);
            end
            if (bus.pending !== m_pending) begin
                failures++;
                $display("[TB] FAIL model_pending t=%0t actual=%b expected=%b", $time, bus.pending, m_pending);
            end
        end
    end

    // Drive one cycle of inputs; returns 1ns after the sampling edge.
    task automatic applyStimulus(input logic [7:0] d, input logic fs);
        bus.din_sync    = d;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    // Literal expectation on all three outputs.
    task automatic checkOutput(input string name, input logic [7:0] exp_out,
                               input logic exp_upd, input logic exp_pend);
        checks += 3;
        if (bus.param_out !== exp_out) begin
            failures++;
            $display("[TB] FAIL %s param_out actual=%h expected=%h", name, bus.param_out, exp_out);
        end
        if (bus.param_upd !== exp_upd) begin
            failures++;
            $display("[TB] FAIL %s param_upd actual=%b expected=%b", name, bus.param_upd, exp_upd);
        end
        if (bus.pending !== exp_pend) begin
            failures++;
            $display("[TB] FAIL %s pending actual=%b expected=%b", name, bus.pending, exp_pend);
        end
    endtask

    initial begin
        logic seen;
        rst             = 1'b1;
        bus.din_sync    = 8'h00;
        bus.frame_start = 1'b0;
`ifdef SYNC_PARAM_FORCE_EN
        bus.force_load  = 1'b0;
`endif
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Constant zero input with periodic frame starts: nothing happens.
        $display("[TB] idle input with frame starts");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'h00, (i % 20) == 19);
            if (bus.pending || bus.param_upd) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL idle_activity actual=1 expected=0");
        end
        checkOutput("idle_end", 8'h00, 1'b0, 1'b0);

        // 0 -> 0x40: pending after four more cycles, commit on frame start.
        $display("[TB] simple update 0x00 -> 0x40");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h40, 1'b0);
            checkOutput("settling", 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(8'h40, 1'b0);
        checkOutput("pending_rise", 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(8'h40, 1'b0);
        checkOutput("pending_hold", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h40, 1'b1);
        checkOutput("commit_40", 8'h40, 1'b1, 1'b0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("upd_one_cycle", 8'h40, 1'b0, 1'b0);

        // Toggling input never qualifies.
        $display("[TB] toggling input");
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus((((i / 2) % 2) == 0) ? 8'h41 : 8'h40, (i % 10) == 5);
            if (bus.pending || bus.param_upd) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL toggle_activity actual=1 expected=0");
        end
        for (int i = 0; i < 6; i++) applyStimulus(8'h40, 1'b0);
        checkOutput("toggle_end", 8'h40, 1'b0, 1'b0);

        // Reset while pending discards the candidate.
        $display("[TB] reset while pending");
        for (int i = 0; i < 5; i++) applyStimulus(8'h77, 1'b0);
        checkOutput("pre_reset_pending", 8'h40, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        checkOutput("reset_mid_pending", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0);

        // Candidate 0x40 abandoned when input moves to 0x22.
        $display("[TB] candidate replaced");
        for (int i = 0; i < 5; i++) applyStimulus(8'h40, 1'b0);
        checkOutput("cand_40_pending", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0);
        checkOutput("cand_dropped", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(8'h22, 1'b0);
        checkOutput("cand_22_pending", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkOutput("commit_22", 8'h22, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b0);

        // Frame start and change in the same cycle: commit wins.
        $display("[TB] simultaneous frame start and change");
        for (int i = 0; i < 5; i++) applyStimulus(8'h40, 1'b0);
        checkOutput("sim_pending_40", 8'h22, 1'b0, 1'b1);
        applyStimulus(8'h10, 1'b1);
        checkOutput("sim_commit_40", 8'h40, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h10, 1'b0);
        checkOutput("sim_settling_10", 8'h40, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("sim_pending_10", 8'h40, 1'b0, 1'b1);
        applyStimulus(8'h10, 1'b1);
        checkOutput("sim_commit_10", 8'h10, 1'b1, 1'b0);
        applyStimulus(8'h10, 1'b0);

`ifdef SYNC_PARAM_FORCE_EN
        // Force load in SETTLE bypasses stability.
        $display("[TB] force load");
        applyStimulus(8'h33, 1'b0);
        checkOutput("force_settle", 8'h10, 1'b0, 1'b0);
        bus.force_load = 1'b1;
        applyStimulus(8'h33, 1'b0);
        bus.force_load = 1'b0;
        checkOutput("force_commit_33", 8'h33, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b0);
        checkOutput("force_after", 8'h33, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 3; i++) applyStimulus(bus.din_sync, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
